led_sequencer: RTL and testbench

Consumer of the divided slow square wave produced by the clock divider. Each toggle of that wave, rising or falling, advances an LED pattern by one step. It sits between the divider and the board LED pins. The slow wave is brought into the fast `in` clock domain and edge-detected. A small FSM then steps one of four patterns: ping-pong, rotate-left, rotate-right or binary count.

---
 rtl/seq_pkg.sv | 15 +
 rtl/led_sequencer_if.sv | 17 +
 rtl/tick_sync.sv | 42 ++++
 rtl/led_sequencer.sv | 108 ++++++++++
 tb/tb_led_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types for the LED sequencer: FSM state encoding and pattern mode codes.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } seq_state_t;

    localparam logic [1:0] MODE_PINGPONG = 2'b00;
    localparam logic [1:0] MODE_ROT_L    = 2'b01;
    localparam logic [1:0] MODE_ROT_R    = 2'b10;
    localparam logic [1:0] MODE_COUNT    = 2'b11;

endpackage

// File: rtl/led_sequencer_if.sv
// Control/pattern bundle between the tick source side and the LED sequencer.
// Handshake: none; tick is a level whose every change is one step request, step/wrap are one-cycle pulses.
interface led_sequencer_if #(parameter int WIDTH = 8);
    import seq_pkg::*;

    logic             tick;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] leds;
    logic             step;
    logic             wrap;
    seq_state_t       state;

    modport master (output tick, en, mode, input leds, step, wrap, state);
    modport slave  (input tick, en, mode, output leds, step, wrap, state);

endinterface

// File: rtl/tick_sync.sv
// Brings the divided tick into the fast domain and emits a one-cycle strobe per level change.
// SEQUENT_SYNC_EN adds a two-flop synchronizer in front of the edge-detect register.
module tick_sync (
    input  logic in,
    input  logic rst_n,
    input  logic tick,
    output logic adv
);

    logic tick_s;
    logic prev_q;

`ifdef SEQUENT_SYNC_EN
    logic s1_q;
    logic s2_q;

    always_ff @(posedge in or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= tick;
            s2_q <= s1_q;
        end
    end

    assign tick_s = s2_q;
`else
    assign tick_s = tick;
`endif

    always_ff @(posedge in or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= tick_s;
        end
    end

    assign adv = tick_s ^ prev_q;

endmodule

// File: rtl/led_sequencer.sv
// Steps a ping-pong / rotate / count LED pattern once per tick level change.
// Latency from tick change to leds is 3 edges with SEQUENT_SYNC_EN defined, 1 edge otherwise.
module led_sequencer
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           in,
    input  logic           rst_n,
    led_sequencer_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             adv;
    logic             onehot;
    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic             step_q;
    logic             wrap_q, wrap_d;

    tick_sync u_tick_sync (
        .in    (in),
        .rst_n (rst_n),
        .tick  (bus.tick),
        .adv   (adv)
    );

    assign onehot = (leds_q != '0) && ((leds_q & (leds_q - ONE)) == '0);

    // Candidate pattern for the next step; only committed when adv arrives in UP/DOWN.
    always_comb begin
        leds_d  = leds_q;
        state_d = state_q;
        wrap_d  = 1'b0;
        if (bus.mode == MODE_COUNT) begin
            leds_d = leds_q + ONE;
            wrap_d = &leds_q;
        end else if (!onehot) begin
            leds_d  = ONE;
            state_d = UP;
        end else begin
            case (bus.mode)
                MODE_ROT_L: begin
                    leds_d  = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
                    wrap_d  = leds_q[WIDTH-1];
                    state_d = UP;
                end
                MODE_ROT_R: begin
                    leds_d  = {leds_q[0], leds_q[WIDTH-1:1]};
                    wrap_d  = leds_q[0];
                    state_d = DOWN;
                end
                default: begin
                    if (state_q == DOWN) begin
                        leds_d = leds_q >> 1;
                        if (leds_d == ONE) begin
                            state_d = UP;
                            wrap_d  = 1'b1;
                        end
                    end else begin
                        leds_d = leds_q << 1;
                        if (leds_d[WIDTH-1]) begin
                            state_d = DOWN;
                            wrap_d  = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            leds_q  <= ONE;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // An adv arriving together with enable is dropped on purpose.
                    if (bus.en) begin
                        state_q <= UP;
                    end
                end
                default: begin
                    if (!bus.en) begin
                        state_q <= IDLE;
                    end else if (adv) begin
                        leds_q  <= leds_d;
                        state_q <= state_d;
                        step_q  <= 1'b1;
                        wrap_q  <= wrap_d;
                    end
                end
            endcase
        end
    end

    assign bus.leds  = leds_q;
    assign bus.step  = step_q;
    assign bus.wrap  = wrap_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer (WIDTH=4): directed pattern table, enable/reset corners, random steps vs a model.
module tb_led_sequencer;
    import seq_pkg::*;

    localparam int W = 4;
`ifdef SEQUENT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_sequencer_if #(.WIDTH(W)) bus ();

    led_sequencer #(.WIDTH(W)) dut (
        .in    (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int step_cnt = 0;
    bit sb_on    = 1'b0;
    logic [W:0] exp_q[$];

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] leds;
        logic         wrap;
    } vec_t;
    vec_t vecs[$];

    int m_val;
    bit m_up;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [1:0] m, input logic [W-1:0] l, input logic w);
        vec_t v;
        v.mode = m;
        v.leds = l;
        v.wrap = w;
        vecs.push_back(v);
    endfunction

    // Reference model: pattern value as an integer, direction as a flag.
    task automatic model_step(input int md, output bit w);
        bit is_onehot;
        is_onehot = (m_val != 0) && ((m_val & (m_val - 1)) == 0);
        w = 1'b0;
        if (md == 3) begin
            w = (m_val == 15);
            m_val = (m_val + 1) % 16;
        end else if (!is_onehot) begin
            m_val = 1;
            m_up  = 1'b1;
        end else if (md == 1) begin
            w = (m_val == 8);
            m_val = (m_val == 8) ? 1 : m_val * 2;
            m_up = 1'b1;
        end else if (md == 2) begin
            w = (m_val == 1);
            m_val = (m_val == 1) ? 8 : m_val / 2;
            m_up = 1'b0;
        end else if (m_up) begin
            m_val = (m_val * 2) % 16;
            if (m_val >= 8) begin
                m_up = 1'b0;
                w = 1'b1;
            end
        end else begin
            m_val = m_val / 2;
            if (m_val == 1) begin
                m_up = 1'b1;
                w = 1'b1;
            end
        end
    endtask

    // driver tasks
    task automatic tick_edge();
        @(posedge clk);
        #1 bus.tick = ~bus.tick;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_check(input string name, input logic [1:0] md, input logic [W-1:0] exp_leds,
                              input logic exp_wrap);
        bus.mode = md;
        tick_edge();
        repeat (LAT) @(posedge clk);
        #1;
        check({name, "_leds"}, bus.leds, exp_leds);
        check({name, "_step"}, bus.step, 1);
        check({name, "_wrap"}, bus.wrap, exp_wrap);
        wait_cyc(1);
        check({name, "_step_drop"}, bus.step, 0);
    endtask

    always @(negedge clk) begin
        if (bus.step === 1'b1) step_cnt++;
    end

    // scoreboard
    always @(negedge clk) begin
        logic [W:0] e;
        if (sb_on && bus.step === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_step: got step with leds %b, expected no step", bus.leds);
            end else begin
                e = exp_q.pop_front();
                check("sb_leds", bus.leds, e[W-1:0]);
                check("sb_wrap", bus.wrap, e[W]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bit w;

        add_vec(MODE_PINGPONG, 4'b0010, 1'b0);
        add_vec(MODE_PINGPONG, 4'b0100, 1'b0);
        add_vec(MODE_PINGPONG, 4'b1000, 1'b1);
        add_vec(MODE_PINGPONG, 4'b0100, 1'b0);
        add_vec(MODE_PINGPONG, 4'b0010, 1'b0);
        add_vec(MODE_PINGPONG, 4'b0001, 1'b1);
        add_vec(MODE_ROT_L, 4'b0010, 1'b0);
        add_vec(MODE_ROT_L, 4'b0100, 1'b0);
        add_vec(MODE_ROT_L, 4'b1000, 1'b0);
        add_vec(MODE_ROT_L, 4'b0001, 1'b1);
        for (int i = 2; i <= 15; i++) add_vec(MODE_COUNT, 4'(i), 1'b0);
        add_vec(MODE_COUNT, 4'b0000, 1'b1);
        for (int i = 1; i <= 5; i++) add_vec(MODE_COUNT, 4'(i), 1'b0);
        add_vec(MODE_ROT_R, 4'b0001, 1'b0);
        add_vec(MODE_ROT_R, 4'b1000, 1'b1);

        // reset with tick toggling
        bus.tick = 1'b0;
        bus.en   = 1'b0;
        bus.mode = MODE_PINGPONG;
        rst_n    = 1'b0;
        repeat (3) #7 bus.tick = ~bus.tick;
        #1;
        check("rst_leds", bus.leds, 4'b0001);
        check("rst_step", bus.step, 0);
        check("rst_wrap", bus.wrap, 0);
        check("rst_state", bus.state, IDLE);
        @(negedge clk) rst_n = 1'b1;

        // disabled: tick toggles ignored
        for (int i = 0; i < 5; i++) begin
            tick_edge();
            wait_cyc(LAT + 1);
        end
        check("hold_leds", bus.leds, 4'b0001);
        check("hold_steps", step_cnt, 0);
        check("hold_state", bus.state, IDLE);

        bus.en = 1'b1;
        wait_cyc(2);
        check("en_state", bus.state, UP);
        for (int i = 0; i < vecs.size(); i++) begin
            step_check($sformatf("vec%0d", i), vecs[i].mode, vecs[i].leds, vecs[i].wrap);
        end

        // en dropped mid-run freezes pattern; re-enable resumes in UP
        step_check("pp_down", MODE_PINGPONG, 4'b0100, 1'b0);
        bus.en = 1'b0;
        wait_cyc(2);
        check("dis_state", bus.state, IDLE);
        s0 = step_cnt;
        for (int i = 0; i < 3; i++) begin
            tick_edge();
            wait_cyc(LAT + 1);
        end
        check("dis_leds", bus.leds, 4'b0100);
        check("dis_steps", step_cnt, s0);
        bus.en = 1'b1;
        wait_cyc(2);
        check("reen_state", bus.state, UP);
        step_check("reen_up", MODE_PINGPONG, 4'b1000, 1'b1);

        // en rising in the same cycle as adv: no step
        bus.en = 1'b0;
        wait_cyc(2);
        s0 = step_cnt;
        bus.mode = MODE_ROT_L;
        tick_edge();
        repeat (LAT - 1) @(posedge clk);
        #1 bus.en = 1'b1;
        @(posedge clk);
        #1;
        check("enadv_step", bus.step, 0);
        check("enadv_leds", bus.leds, 4'b1000);
        check("enadv_state", bus.state, UP);
        wait_cyc(LAT + 1);
        check("enadv_steps", step_cnt, s0);
        step_check("enadv_after", MODE_ROT_L, 4'b0001, 1'b1);
        step_check("pre_rst", MODE_ROT_L, 4'b0010, 1'b0);

        // reset between sync stages
        if (bus.tick == 1'b0) begin
            bus.en = 1'b0;
            tick_edge();
            wait_cyc(LAT + 1);
            bus.en = 1'b1;
            wait_cyc(2);
        end
        tick_edge();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_leds", bus.leds, 4'b0001);
        check("midrst_step", bus.step, 0);
        check("midrst_state", bus.state, IDLE);
        @(negedge clk) rst_n = 1'b1;
        s0 = step_cnt;
        wait_cyc(LAT + 5);
        check("midrst_steps", step_cnt, s0);
        check("midrst_leds_after", bus.leds, 4'b0001);

        // random steps against the model
        rst_n = 1'b0;
        bus.tick = 1'b0;
        #3;
        @(negedge clk) rst_n = 1'b1;
        bus.en = 1'b1;
        wait_cyc(2);
        m_val = 1;
        m_up  = 1'b1;
        sb_on = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int md;
            md = $urandom_range(0, 3);
            bus.mode = 2'(md);
            model_step(md, w);
            exp_q.push_back({w, 4'(m_val)});
            tick_edge();
            wait_cyc(LAT + $urandom_range(1, 3));
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("sb_drain", exp_q.size(), 0);
        sb_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
